jtag_vector_engine: RTL and testbench

//  Plays JTAG vectors from vector_1 RAM (port B) onto TCK/TMS/TDI pins and stores sampled TDO into vector_2 RAM.

---
 rtl/jtag_pkg.sv | 36 +++
 rtl/jtag_vector_engine_if.sv | 30 +++
 rtl/jtag_vector_engine_bit_sync.sv | 24 ++
 rtl/jtag_vector_engine.sv | 214 +++++++++++++++++++++
 tb/tb_jtag_vector_engine.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG vector engine: FSM states, vector byte layout
// and the bit-index width derived from the longest supported run.
package jtag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOW,
        ST_HIGH,
        ST_STORE,
        ST_FIN
    } state_t;

    // Each vector_1 byte holds four JTAG cycles: TDI nibble low, TMS nibble high.
    localparam int TDI_LSB  = 0;
    localparam int TMS_LSB  = 4;

    localparam int MAX_BITS = 16384;
    // One extra bit so the index can hold MAX_BITS itself.
    localparam int N_W      = $clog2(MAX_BITS) + 1;

    // A zero half-period would never terminate the LOW/HIGH timers.
    function automatic logic [31:0] clamp_width(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

    // Returns {tms, tdi} for cycle i (0..3) of a vector byte.
    function automatic logic [1:0] pins_for(input logic [7:0] b, input logic [1:0] i);
        logic [3:0] tdi_nib;
        logic [3:0] tms_nib;
        tdi_nib = b[TDI_LSB +: 4];
        tms_nib = b[TMS_LSB +: 4];
        return {tms_nib[i], tdi_nib[i]};
    endfunction

endpackage

// File: rtl/jtag_vector_engine_if.sv
// Control strobes, run configuration and the two vector RAM ports shared
// between main_ram (master) and the JTAG vector engine (slave).
interface jtag_vector_engine_if;

    logic        jtag_rst;
    logic        jtag_wr;
    logic [14:0] bit_count;
    logic [31:0] tck_width;
    logic [31:0] tdo_delay;
    logic        busy;
    logic        done;

    logic [11:0] vector_1_addr;
    logic [7:0]  vector_1_rd_data;

    logic [11:0] vector_2_addr;
    logic        vector_2_we;
    logic [7:0]  vector_2_wr_data;

    modport master (
        output jtag_rst, jtag_wr, bit_count, tck_width, tdo_delay, vector_1_rd_data,
        input  busy, done, vector_1_addr, vector_2_addr, vector_2_we, vector_2_wr_data
    );

    modport slave (
        input  jtag_rst, jtag_wr, bit_count, tck_width, tdo_delay, vector_1_rd_data,
        output busy, done, vector_1_addr, vector_2_addr, vector_2_we, vector_2_wr_data
    );

endinterface

// File: rtl/jtag_vector_engine_bit_sync.sv
// Multi-flop synchronizer bringing the asynchronous TDO pin into the clk domain.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the pin value through the flop chain; the last stage is the clean copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/jtag_vector_engine.sv
// Plays TMS/TDI vectors from vector_1 onto the JTAG pins and packs sampled TDO
// bits into vector_2, one run per jtag_wr pulse.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | waiting for jtag_wr; pins hold their last values
//  FETCH    | vector_1 address presented, waiting out the RAM read latency
//  LOW      | tck low, tms/tdi for bit n driven, half-period timer running
//  HIGH     | tck high, TDO sampled at the clamped delay, then advance n
//  STORE    | write the packed TDO byte (or final partial byte) to vector_2
//  FIN      | one-cycle done pulse, back to IDLE
module jtag_vector_engine
    import jtag_pkg::*;
#(
    parameter int RD_LATENCY  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    jtag_vector_engine_if.slave  bus,
    output logic                 tck,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo
);

    state_t           state, state_nxt;
    logic [N_W-1:0]   n, n_nxt, n_inc;
    logic [N_W-1:0]   count, count_nxt;
    logic [31:0]      cnt, cnt_nxt;
    logic [31:0]      width, width_nxt;
    logic [31:0]      samp, samp_nxt;
    logic [31:0]      width_c, samp_c, tc;
    logic [7:0]       byte_q, byte_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [11:0]      addr1, addr1_nxt;
    logic [11:0]      store_addr;
    logic             tck_nxt, tms_nxt, tdi_nxt;
    logic             done_q, done_nxt;
    logic             running;
    logic             tdo_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_tdo_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tdo),
        .q     (tdo_s)
    );

    assign running = (state == ST_FETCH) || (state == ST_LOW) ||
                     (state == ST_HIGH)  || (state == ST_STORE);

    // n has already advanced past the last captured bit when STORE is reached.
    assign store_addr = n[N_W-1:3] - {11'd0, (n[2:0] == 3'd0)};

    assign bus.busy             = running;
    assign bus.done             = done_q;
    assign bus.vector_1_addr    = addr1;
    assign bus.vector_2_we      = (state == ST_STORE);
    assign bus.vector_2_addr    = (state == ST_STORE) ? store_addr : 12'd0;
    assign bus.vector_2_wr_data = (state == ST_STORE) ? shift : 8'd0;

    // Next-state, timer and pin decisions for the whole engine.
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        count_nxt = count;
        cnt_nxt   = cnt;
        width_nxt = width;
        samp_nxt  = samp;
        byte_nxt  = byte_q;
        shift_nxt = shift;
        addr1_nxt = addr1;
        tck_nxt   = tck;
        tms_nxt   = tms;
        tdi_nxt   = tdi;
        done_nxt  = 1'b0;

        width_c = clamp_width(bus.tck_width);
        // A delay past the end of HIGH samples on the final HIGH cycle instead.
        samp_c  = (bus.tdo_delay < width_c) ? bus.tdo_delay : (width_c - 32'd1);
        tc      = width - 32'd1;
        n_inc   = n + N_W'(1);

        if (bus.jtag_rst) begin
            state_nxt = ST_IDLE;
            tck_nxt   = 1'b0;
            tms_nxt   = 1'b1;
            done_nxt  = running;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.jtag_wr) begin
                        count_nxt = bus.bit_count;
                        width_nxt = width_c;
                        samp_nxt  = samp_c;
                        n_nxt     = '0;
                        cnt_nxt   = 32'd0;
                        shift_nxt = 8'd0;
                        addr1_nxt = 12'd0;
                        if (bus.bit_count != 15'd0) begin
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_FIN;
                            done_nxt  = 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    if (cnt == 32'(RD_LATENCY)) begin
                        byte_nxt             = bus.vector_1_rd_data;
                        {tms_nxt, tdi_nxt}   = pins_for(bus.vector_1_rd_data, n[1:0]);
                        tck_nxt              = 1'b0;
                        cnt_nxt              = 32'd0;
                        state_nxt            = ST_LOW;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end

                ST_LOW: begin
                    if (cnt == tc) begin
                        tck_nxt   = 1'b1;
                        cnt_nxt   = 32'd0;
                        state_nxt = ST_HIGH;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end

                ST_HIGH: begin
                    if (cnt == samp) begin
                        shift_nxt[n[2:0]] = tdo_s;
                    end
                    if (cnt == tc) begin
                        tck_nxt = 1'b0;
                        cnt_nxt = 32'd0;
                        n_nxt   = n_inc;
                        if ((n_inc[2:0] == 3'd0) || (n_inc == count)) begin
                            state_nxt = ST_STORE;
                        end else if (n_inc[1:0] == 2'd0) begin
                            state_nxt = ST_FETCH;
                            addr1_nxt = n_inc[13:2];
                        end else begin
                            state_nxt          = ST_LOW;
                            {tms_nxt, tdi_nxt} = pins_for(byte_q, n_inc[1:0]);
                        end
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end

                ST_STORE: begin
                    // Clearing here keeps the unfilled bits of a final partial byte at 0.
                    shift_nxt = 8'd0;
                    cnt_nxt   = 32'd0;
                    if (n == count) begin
                        state_nxt = ST_FIN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_FETCH;
                        addr1_nxt = n[13:2];
                    end
                end

                ST_FIN: begin
                    tck_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; tms resets high to steer the TAP toward Test-Logic-Reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            n      <= '0;
            count  <= '0;
            cnt    <= 32'd0;
            width  <= 32'd1;
            samp   <= 32'd0;
            byte_q <= 8'd0;
            shift  <= 8'd0;
            addr1  <= 12'd0;
            tck    <= 1'b0;
            tms    <= 1'b1;
            tdi    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            n      <= n_nxt;
            count  <= count_nxt;
            cnt    <= cnt_nxt;
            width  <= width_nxt;
            samp   <= samp_nxt;
            byte_q <= byte_nxt;
            shift  <= shift_nxt;
            addr1  <= addr1_nxt;
            tck    <= tck_nxt;
            tms    <= tms_nxt;
            tdi    <= tdi_nxt;
            done_q <= done_nxt;
        end
    end

endmodule

// File: tb/tb_jtag_vector_engine.sv
// Directed bench for jtag_vector_engine: a two-stage vector_1 RAM model, a
// pin/strobe monitor, and hand-computed expectations per scenario.
module tb_jtag_vector_engine;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tck, tms, tdi, tdo;

    jtag_vector_engine_if bus();

    jtag_vector_engine #(
        .RD_LATENCY  (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tck   (tck),
        .tms   (tms),
        .tdi   (tdi),
        .tdo   (tdo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // vector_1 RAM: address register then output register
    logic [7:0]  v1_mem [4096];
    logic [11:0] a_r = 12'd0;
    logic [7:0]  q_r = 8'd0;
    always @(posedge clk) begin
        a_r <= bus.vector_1_addr;
        q_r <= v1_mem[a_r];
    end
    assign bus.vector_1_rd_data = q_r;

    // monitor state
    int          rise_cnt = 0;
    int          rise_base = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          busy_cyc = 0;
    int          hi_run = 0;
    int          hi_len [16];
    logic        prev_tck = 1'b0;
    logic [15:0] tms_hist = 16'd0;
    logic [15:0] tdi_hist = 16'd0;
    logic [15:0] tdo_pat = 16'hFFFF;
    logic [7:0]  v2_mem [4096];
    logic [11:0] last_addr = 12'd0;
    logic [3:0]  ridx, fidx;

    assign ridx = 4'(rise_cnt - rise_base);
    assign fidx = 4'(rise_cnt - rise_base - 1);
    // TDO for bit k is presented after the k-th TCK rise of the run
    assign tdo  = tdo_pat[ridx];

    always @(negedge clk) begin
        prev_tck <= tck;
        if (tck && !prev_tck) begin
            tms_hist[ridx] <= tms;
            tdi_hist[ridx] <= tdi;
            rise_cnt       <= rise_cnt + 1;
            hi_run         <= 1;
        end else if (tck) begin
            hi_run <= hi_run + 1;
        end
        if (!tck && prev_tck) hi_len[fidx] <= hi_run;
        if (bus.vector_2_we) begin
            v2_mem[bus.vector_2_addr] <= bus.vector_2_wr_data;
            last_addr                 <= bus.vector_2_addr;
            wr_cnt                    <= wr_cnt + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.busy) busy_cyc <= busy_cyc + 1;
    end

    int wr0, done0, busy0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [14:0] bc, input logic [31:0] w, input logic [31:0] d,
                         input logic [15:0] pat);
        @(negedge clk);
        #1;
        rise_base         = rise_cnt;
        tdo_pat           = pat;
        wr0               = wr_cnt;
        done0             = done_cnt;
        busy0             = busy_cyc;
        bus.bit_count     = bc;
        bus.tck_width     = w;
        bus.tdo_delay     = d;
        bus.jtag_wr       = 1'b1;
        @(posedge clk);
        #1;
        bus.jtag_wr       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        bus.jtag_rst  = 1'b0;
        bus.jtag_wr   = 1'b0;
        bus.bit_count = 15'd0;
        bus.tck_width = 32'd0;
        bus.tdo_delay = 32'd0;
        for (int i = 0; i < 4096; i++) v1_mem[i] = 8'h00;

        #1 reset = 1'b1;
        #12;
        check("rst_tck",  tck, 1'b0);
        check("rst_tms",  tms, 1'b1);
        check("rst_tdi",  tdi, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_we",   bus.vector_2_we, 1'b0);
        check("rst_buses", {bus.vector_1_addr, bus.vector_2_addr, bus.vector_2_wr_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: four bits, width 2, byte 0x5A, tdo high
        v1_mem[0] = 8'h5A;
        start(15'd4, 32'd2, 32'd0, 16'hFFFF);
        check("t1_busy_now", bus.busy, 1'b1);
        wait_done("t1_done", 200);
        check("t1_v2", v2_mem[0], 8'h0F);
        check("t1_writes", wr_cnt - wr0, 1);
        check("t1_busy_cyc", busy_cyc - busy0, 20);
        check("t1_rises", rise_cnt - rise_base, 4);
        check("t1_tms", tms_hist[3:0], 4'b0101);
        check("t1_tdi", tdi_hist[3:0], 4'b1010);
        check("t1_done_cnt", done_cnt - done0, 1);
        for (int i = 0; i < 4; i++) check($sformatf("t1_hi%0d", i), hi_len[i], 2);

        // 2: sixteen bits, width 1, alternating tdo
        v1_mem[0] = 8'h5A; v1_mem[1] = 8'h33; v1_mem[2] = 8'hC3; v1_mem[3] = 8'h0F;
        start(15'd16, 32'd1, 32'd0, 16'h5555);
        wait_done("t2_done", 300);
        check("t2_v2_0", v2_mem[0], 8'h55);
        check("t2_v2_1", v2_mem[1], 8'h55);
        check("t2_writes", wr_cnt - wr0, 2);
        check("t2_busy_cyc", busy_cyc - busy0, 46);
        check("t2_tdi", tdi_hist, 16'hF33A);
        check("t2_tms", tms_hist, 16'h0C35);

        // 3: width 0 runs as 1, huge delay clamps, partial byte
        v1_mem[0] = 8'h5A;
        start(15'd3, 32'd0, 32'd100, 16'hFFFF);
        wait_done("t3_done", 200);
        check("t3_v2", v2_mem[0], 8'h07);
        check("t3_busy_cyc", busy_cyc - busy0, 10);
        for (int i = 0; i < 3; i++) check($sformatf("t3_hi%0d", i), hi_len[i], 1);

        // 3b: tdo rises just after TCK rise; early sample sees 0, clamped sample sees 1
        start(15'd1, 32'd4, 32'd1, 16'h0002);
        wait_done("t3b_done", 200);
        check("t3b_early", v2_mem[0], 8'h00);
        check("t3b_busy_cyc", busy_cyc - busy0, 12);
        start(15'd1, 32'd4, 32'd100, 16'h0002);
        wait_done("t3c_done", 200);
        check("t3c_clamped", v2_mem[0], 8'h01);

        // 5a: zero-length run
        start(15'd0, 32'd2, 32'd0, 16'hFFFF);
        check("t5a_done", bus.done, 1'b1);
        check("t5a_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        check("t5a_done_low", bus.done, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("t5a_rises", rise_cnt - rise_base, 0);
        check("t5a_writes", wr_cnt - wr0, 0);

        // 5b: jtag_wr during a run is ignored
        v1_mem[0] = 8'h5A; v1_mem[1] = 8'h33;
        start(15'd8, 32'd1, 32'd0, 16'hFFFF);
        repeat (5) @(negedge clk);
        #1;
        bus.bit_count = 15'd16;
        bus.jtag_wr   = 1'b1;
        @(negedge clk);
        #1;
        bus.jtag_wr   = 1'b0;
        wait_done("t5b_done", 200);
        check("t5b_rises", rise_cnt - rise_base, 8);
        check("t5b_writes", wr_cnt - wr0, 1);
        check("t5b_busy_cyc", busy_cyc - busy0, 23);
        check("t5b_v2", v2_mem[0], 8'hFF);
        check("t5b_done_cnt", done_cnt - done0, 1);

        // 4: abort mid-run, with a simultaneous jtag_wr
        begin
            int wr_abort;
            start(15'd10000, 32'd3, 32'd0, 16'hFFFF);
            repeat (150) @(negedge clk);
            #1;
            bus.jtag_rst  = 1'b1;
            bus.jtag_wr   = 1'b1;
            bus.bit_count = 15'd4;
            @(posedge clk);
            #1;
            check("t4_tck", tck, 1'b0);
            check("t4_tms", tms, 1'b1);
            check("t4_busy", bus.busy, 1'b0);
            check("t4_done", bus.done, 1'b1);
            check("t4_we", bus.vector_2_we, 1'b0);
            @(negedge clk);
            #1;
            bus.jtag_rst = 1'b0;
            bus.jtag_wr  = 1'b0;
            wr_abort     = wr_cnt;
            check("t4_pre_writes", (wr_abort - wr0) > 0, 1'b1);
            @(posedge clk);
            #1;
            check("t4_done_low", bus.done, 1'b0);
            repeat (40) @(negedge clk);
            #1;
            check("t4_no_writes", wr_cnt - wr_abort, 0);
            check("t4_done_cnt", done_cnt - done0, 1);
            check("t4_idle", bus.busy, 1'b0);
        end

        // 5c: full-range run
        start(15'h4000, 32'd1, 32'd0, 16'hFFFF);
        wait_done("t5c_done", 60000);
        check("t5c_last_addr", last_addr, 12'h7FF);
        check("t5c_writes", wr_cnt - wr0, 2048);
        check("t5c_rises", rise_cnt - rise_base, 16384);
        check("t5c_v2_last", v2_mem[12'h7FF], 8'hFF);

        // 6: async reset while TCK is high
        begin
            logic hit;
            hit = 1'b0;
            v1_mem[0] = 8'h0F;
            start(15'd4, 32'd4, 32'd0, 16'hFFFF);
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge clk);
                if (tck) hit = 1'b1;
            end
            check("t6_reached_high", hit, 1'b1);
            #2;
            reset = 1'b1;
            #1;
            check("t6_tck", tck, 1'b0);
            check("t6_tms", tms, 1'b1);
            check("t6_tdi", tdi, 1'b0);
            check("t6_busy", bus.busy, 1'b0);
            check("t6_done", bus.done, 1'b0);
            check("t6_we", bus.vector_2_we, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("t6_stays_idle", bus.busy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
